// File: rtl/vdec_mem_arbiter_if.sv
// Read-port bus shared by the four video RAM requesters, the arbiter and the RAM controller.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface vdec_mem_arbiter_if;
  logic [3:0]       req_as;
  logic [3:0][21:0] req_address;
  logic [3:0]       req_ack;
  logic [15:0]      req_din;
  logic             mem_as;
  logic [21:0]      mem_address;
  logic [15:0]      mem_din;
  logic             mem_ack;
  logic [3:0]       grant;

  modport master (
    output req_as, req_address, mem_din, mem_ack,
    input  req_ack, req_din, mem_as, mem_address, grant
  );

  modport slave (
    input  req_as, req_address, mem_din, mem_ack,
    output req_ack, req_din, mem_as, mem_address, grant
  );
endinterface

// File: rtl/vdec_mem_arbiter.sv
// Video RAM read-port arbiter: class priority (pixel fetch over ICA/DCA), round-robin inside a
// class, burst ownership while the owner holds as, forced release after MAX_BURST acked words.
module vdec_mem_arbiter #(
  parameter int unsigned MAX_BURST = 8
) (
  input logic               clk,
  input logic               reset,
  vdec_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t     state;
  logic [1:0] owner;
  logic [3:0] grant_q;
  logic [7:0] burst_cnt;
  logic       last_a;
  logic       last_b;

  logic [1:0] winner;
  logic       owner_as;
  logic       owner_ack;
  logic [7:0] burst_next;
  logic       competitor;
  logic       at_limit;

  // last_a/last_b hold the low bit of the previous winner of each class; a tie goes to the other port.
  always_comb begin
    winner = 2'd0;
    if (bus.req_as[0] && bus.req_as[1])
      winner = last_a ? 2'd0 : 2'd1;
    else if (bus.req_as[0])
      winner = 2'd0;
    else if (bus.req_as[1])
      winner = 2'd1;
    else if (bus.req_as[2] && bus.req_as[3])
      winner = last_b ? 2'd2 : 2'd3;
    else if (bus.req_as[2])
      winner = 2'd2;
    else if (bus.req_as[3])
      winner = 2'd3;
  end

  always_comb begin
    competitor = 1'b0;
    for (int p = 0; p < 4; p++) begin
      if (bus.req_as[p] && (p[1:0] != owner) && (!p[1] || owner[1]))
        competitor = 1'b1;
    end
  end

  assign owner_as   = bus.req_as[owner];
  assign owner_ack  = (state == GRANT) && bus.mem_ack;
  assign burst_next = (owner_ack && (burst_cnt != 8'hFF)) ? burst_cnt + 8'd1 : burst_cnt;
  assign at_limit   = 32'(burst_next) >= MAX_BURST;

  // Acks outside GRANT have no owner to go to and are dropped.
  always_comb begin
    bus.mem_as      = 1'b0;
    bus.mem_address = '0;
    bus.req_ack     = '0;
    if (state == GRANT) begin
      bus.mem_as          = owner_as;
      bus.mem_address     = bus.req_address[owner];
      bus.req_ack[owner]  = bus.mem_ack;
    end
  end

  assign bus.req_din = bus.mem_din;
  assign bus.grant   = grant_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= 2'd0;
      grant_q   <= 4'b0000;
      burst_cnt <= 8'd0;
      last_a    <= 1'b1;
      last_b    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req_as) begin
            state     <= GRANT;
            owner     <= winner;
            grant_q   <= 4'b0001 << winner;
            burst_cnt <= 8'd0;
            if (winner[1])
              last_b <= winner[0];
            else
              last_a <= winner[0];
          end
        end
        GRANT: begin
          burst_cnt <= burst_next;
          if (!owner_as || (at_limit && competitor)) begin
            state   <= RELEASE;
            grant_q <= 4'b0000;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
